// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared encodings and constants for the BCD operand entry path.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int         NIBBLE_W = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // Step codes double as the LED display value.
    typedef enum logic [2:0] {
        X_TENS = 3'd0,
        X_ONES = 3'd1,
        Y_TENS = 3'd2,
        Y_ONES = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Synchronizes and debounces an active-low key; strobes on press.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw_n,
    output logic o_level,
    output logic o_fall
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic               r_fall;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw_n};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                // Counter holds at max; it clears once the levels agree again.
                r_level <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/bcd_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : bcd_operand_entry
// Purpose  : Keyed entry of two 2-digit BCD operands for the adder stage.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_operand_entry
    import bcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [0:3] digit_in,
    input  logic       enter_n,
    output logic [0:7] x_bcd,
    output logic [0:7] y_bcd,
    output logic       valid,
    output logic       err,
    output logic [0:2] step
);

    logic   w_level;
    logic   w_fall;
    logic   w_press;
    logic   w_digit_ok;

    state_t                 r_state, w_state_nxt;
    logic [0:2*NIBBLE_W-1]  r_x, r_y, w_x_nxt, w_y_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_valid;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_raw_n (enter_n),
        .o_level (w_level),
        .o_fall  (w_fall)
    );

    assign w_press    = w_fall & ~w_level;
    assign w_digit_ok = (digit_in <= BCD_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= X_TENS;
            r_x     <= '0;
            r_y     <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_err   <= w_err_nxt;
            r_valid <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_err_nxt   = r_err;
        case (r_state)
            X_TENS, X_ONES, Y_TENS, Y_ONES: begin
                if (w_press) begin
                    if (w_digit_ok) begin
                        w_err_nxt = 1'b0;
                        case (r_state)
                            X_TENS:  begin w_x_nxt[0:3] = digit_in; w_state_nxt = X_ONES; end
                            X_ONES:  begin w_x_nxt[4:7] = digit_in; w_state_nxt = Y_TENS; end
                            Y_TENS:  begin w_y_nxt[0:3] = digit_in; w_state_nxt = Y_ONES; end
                            default: begin w_y_nxt[4:7] = digit_in; w_state_nxt = DONE;   end
                        endcase
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                // Any press starts a fresh entry; the switch value is not used.
                if (w_press) begin
                    w_state_nxt = X_TENS;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = X_TENS;
        endcase
    end

    assign x_bcd = r_x;
    assign y_bcd = r_y;
    assign err   = r_err;
    assign valid = r_valid;
    assign step  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bcd_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_operand_entry
// Purpose  : Directed self-checking bench for bcd_operand_entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_operand_entry;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:3] digit_in;
    logic       enter_n;
    logic [0:7] x_bcd;
    logic [0:7] y_bcd;
    logic       valid;
    logic       err;
    logic [0:2] step;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_operand_entry #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .digit_in (digit_in),
        .enter_n  (enter_n),
        .x_bcd    (x_bcd),
        .y_bcd    (y_bcd),
        .valid    (valid),
        .err      (err),
        .step     (step)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [0:3] d);
        digit_in = d;
        enter_n  = 1'b0;
        repeat (10) tick();
        enter_n  = 1'b1;
        repeat (10) tick();
    endtask

    task automatic check_all(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                             input logic ev, input logic ee, input logic [2:0] es);
        check_eq({tag, ".x"},     32'(x_bcd), 32'(ex));
        check_eq({tag, ".y"},     32'(y_bcd), 32'(ey));
        check_eq({tag, ".valid"}, 32'(valid), 32'(ev));
        check_eq({tag, ".err"},   32'(err),   32'(ee));
        check_eq({tag, ".step"},  32'(step),  32'(es));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        enter_n  = 1'b1;
        digit_in = 4'd0;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle", 32'({x_bcd, y_bcd, valid, err, step}), 32'd0);
        end

        // 4,7,2 then 9 with exact latency check.
        press_digit(4'd4);
        check_all("d4", 8'h40, 8'h00, 1'b0, 1'b0, 3'd1);
        press_digit(4'd7);
        check_all("d7", 8'h47, 8'h00, 1'b0, 1'b0, 3'd2);
        press_digit(4'd2);
        check_all("d2", 8'h47, 8'h20, 1'b0, 1'b0, 3'd3);
        digit_in = 4'd9;
        enter_n  = 1'b0;
        repeat (6) tick();
        check_all("d9_pre", 8'h47, 8'h20, 1'b0, 1'b0, 3'd3);
        tick();
        check_all("d9_k7", 8'h47, 8'h29, 1'b1, 1'b0, 3'd4);
        repeat (3) tick();
        enter_n = 1'b1;
        repeat (10) tick();
        check_all("done_hold", 8'h47, 8'h29, 1'b1, 1'b0, 3'd4);

        // Press in DONE restarts and ignores the digit.
        press_digit(4'd5);
        check_all("restart", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);

        // Bad digit in X_ONES, then a good one.
        press_digit(4'd1);
        check_all("x1", 8'h10, 8'h00, 1'b0, 1'b0, 3'd1);
        press_digit(4'b1100);
        check_all("bad", 8'h10, 8'h00, 1'b0, 1'b1, 3'd1);
        press_digit(4'd3);
        check_all("recover", 8'h13, 8'h00, 1'b0, 1'b0, 3'd2);

        // Short glitches never register.
        digit_in = 4'd6;
        for (int i = 0; i < 10; i++) begin
            enter_n = 1'b0;
            repeat (3) tick();
            enter_n = 1'b1;
            repeat (3) tick();
        end
        repeat (6) tick();
        check_all("glitch", 8'h13, 8'h00, 1'b0, 1'b0, 3'd2);

        // Long hold advances exactly once.
        digit_in = 4'd5;
        enter_n  = 1'b0;
        repeat (200) tick();
        check_all("hold", 8'h13, 8'h50, 1'b0, 1'b0, 3'd3);
        enter_n = 1'b1;
        repeat (10) tick();
        check_all("hold_rel", 8'h13, 8'h50, 1'b0, 1'b0, 3'd3);

        // Reset one cycle before a pending press would be accepted.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        press_digit(4'd6);
        press_digit(4'd8);
        check_all("pre_rst", 8'h68, 8'h00, 1'b0, 1'b0, 3'd2);
        digit_in = 4'd1;
        enter_n  = 1'b0;
        repeat (4) tick();
        reset   = 1'b1;
        enter_n = 1'b1;
        tick();
        check_all("rst_edge", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
        repeat (12) tick();
        check_all("rst_lost", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);

        // X=99, Y=99, then leave DONE with latency check.
        repeat (4) press_digit(4'd9);
        check_all("nines", 8'h99, 8'h99, 1'b1, 1'b0, 3'd4);
        digit_in = 4'd3;
        enter_n  = 1'b0;
        repeat (6) tick();
        check_all("leave_pre", 8'h99, 8'h99, 1'b1, 1'b0, 3'd4);
        tick();
        check_all("leave", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
        enter_n = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
